bp_resolve_ctrl: RTL and testbench

Branch-resolution controller for the gshare predictor. It drives the predictor's lookup port on every fetched branch and records each prediction in an in-order resolution queue. As execute resolves branches, it compares the actual outcome with the stored prediction, flags mispredictions and sequences the predictor's edge-triggered `update` input as a clean one-cycle pulse. It sits between fetch, execute and the predictor instance.

---
 rtl/bp_resolve_ctrl_if.sv | 42 ++++
 rtl/bp_resolve_ctrl.sv | 136 +++++++++++++
 tb/tb_bp_resolve_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_resolve_ctrl_if.sv
// Fetch/predictor/execute-facing signal bundle for bp_resolve_ctrl.
// slave = controller view, master = environment (fetch, execute, predictor) view.
interface bp_resolve_ctrl_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic [6:0]        fetch_opcode;
  logic              fetch_ready;
  logic              fetch_pred;
  logic              pred_start;
  logic [ADDR_W-1:0] pred_addr;
  logic [6:0]        pred_opcode;
  logic              pred_in;
  logic              resolve_valid;
  logic              resolve_taken;
  logic              resolve_ready;
  logic              mispredict;
  logic [ADDR_W-1:0] mispredict_addr;
  logic              mispredict_taken;
  logic              upd_strobe;
  logic [ADDR_W-1:0] upd_addr;
  logic              upd_taken;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  fetch_valid, fetch_addr, fetch_opcode, pred_in, resolve_valid, resolve_taken,
    output fetch_ready, fetch_pred, pred_start, pred_addr, pred_opcode, resolve_ready,
           mispredict, mispredict_addr, mispredict_taken, upd_strobe, upd_addr,
           upd_taken, count
  );

  modport master (
    output fetch_valid, fetch_addr, fetch_opcode, pred_in, resolve_valid, resolve_taken,
    input  fetch_ready, fetch_pred, pred_start, pred_addr, pred_opcode, resolve_ready,
           mispredict, mispredict_addr, mispredict_taken, upd_strobe, upd_addr,
           upd_taken, count
  );
endinterface

// File: rtl/bp_resolve_ctrl.sv
// Branch-resolution controller: in-order prediction queue, mispredict flush and
// a high/low sequenced update pulse toward an edge-triggered gshare predictor.
module bp_resolve_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  bp_resolve_ctrl_if.slave bus
);
  localparam int         PTR_W      = $clog2(DEPTH);
  localparam int         CNT_W      = $clog2(DEPTH + 1);
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, UPD_HI, UPD_LO} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic              r_q_pred [DEPTH];
  logic              r_q_cond [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_mispredict;
  logic [ADDR_W-1:0] r_mis_addr;
  logic              r_mis_taken;
  logic              r_upd_strobe;
  logic [ADDR_W-1:0] r_upd_addr;
  logic              r_upd_taken;

  logic              w_fetch_ready;
  logic              w_resolve_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_mis;
  logic              w_upd_go;
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_head_pred;
  logic              w_head_cond;

  assign w_fetch_ready   = (r_count != CNT_W'(DEPTH));
  assign w_resolve_ready = (r_count != '0) && (r_state == IDLE);
  assign w_push          = bus.fetch_valid && w_fetch_ready;
  assign w_pop           = bus.resolve_valid && w_resolve_ready;

  assign w_head_addr = r_q_addr[r_rd_ptr];
  assign w_head_pred = r_q_pred[r_rd_ptr];
  assign w_head_cond = r_q_cond[r_rd_ptr];

  assign w_mis    = w_pop && (w_head_pred != bus.resolve_taken);
  assign w_upd_go = w_pop && w_head_cond;

  // Lookup path is purely combinational so fetch sees the prediction in the push cycle.
  assign bus.pred_start  = w_push;
  assign bus.pred_addr   = bus.fetch_addr;
  assign bus.pred_opcode = bus.fetch_opcode;
  assign bus.fetch_pred  = w_push ? bus.pred_in : 1'b0;
  assign bus.fetch_ready = w_fetch_ready;

  assign bus.resolve_ready    = w_resolve_ready;
  assign bus.mispredict       = r_mispredict;
  assign bus.mispredict_addr  = r_mis_addr;
  assign bus.mispredict_taken = r_mis_taken;
  assign bus.upd_strobe       = r_upd_strobe;
  assign bus.upd_addr         = r_upd_addr;
  assign bus.upd_taken        = r_upd_taken;
  assign bus.count            = r_count;

  // A push coinciding with a flush is wrong-path and never lands in the queue.
  always_ff @(posedge clk) begin
    if (w_push && !w_mis) begin
      r_q_addr[r_wr_ptr] <= bus.fetch_addr;
      r_q_pred[r_wr_ptr] <= bus.pred_in;
      r_q_cond[r_wr_ptr] <= (bus.fetch_opcode == OPC_BRANCH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_mis) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispredict <= 1'b0;
      r_mis_addr   <= '0;
      r_mis_taken  <= 1'b0;
    end else begin
      r_mispredict <= w_mis;
      if (w_mis) begin
        r_mis_addr  <= w_head_addr;
        r_mis_taken <= bus.resolve_taken;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_upd_strobe <= 1'b0;
      r_upd_addr   <= '0;
      r_upd_taken  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_upd_strobe <= (w_state_next == UPD_HI);
      if (w_upd_go) begin
        r_upd_addr  <= w_head_addr;
        r_upd_taken <= bus.resolve_taken;
      end
    end
  end

  // UPD_LO forces a low cycle so back-to-back updates give distinct rising edges.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_upd_go) w_state_next = UPD_HI;
      UPD_HI:  w_state_next = UPD_LO;
      UPD_LO:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// Randomized and directed bench for bp_resolve_ctrl against a queue-based model.
module tb_bp_resolve_ctrl;
  localparam int         DEPTH  = 4;
  localparam int         ADDR_W = 8;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              pred;
    logic              cond;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;

  bp_resolve_ctrl_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  bp_resolve_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: pending predictions as a queue, update sequencer as a busy countdown.
  ent_t              q[$];
  int                busy;
  logic              m_mis;
  logic [ADDR_W-1:0] m_mis_addr;
  logic              m_mis_taken;
  logic [ADDR_W-1:0] m_upd_addr;
  logic              m_upd_taken;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    busy        = 0;
    m_mis       = 1'b0;
    m_mis_addr  = '0;
    m_mis_taken = 1'b0;
    m_upd_addr  = '0;
    m_upd_taken = 1'b0;
  endtask

  task automatic model_step();
    bit   ready, rready, push, pop;
    ent_t head, nw;
    if (!rst_n) return;
    ready  = (q.size() != DEPTH);
    rready = (q.size() != 0) && (busy == 0);
    push   = bus.fetch_valid && ready;
    pop    = bus.resolve_valid && rready;
    nw.addr = bus.fetch_addr;
    nw.pred = bus.pred_in;
    nw.cond = (bus.fetch_opcode == BR);
    m_mis = 1'b0;
    if (busy > 0) busy--;
    if (pop) begin
      head = q[0];
      if (head.cond) begin
        m_upd_addr  = head.addr;
        m_upd_taken = bus.resolve_taken;
        busy        = 2;
      end
      if (head.pred != bus.resolve_taken) begin
        m_mis       = 1'b1;
        m_mis_addr  = head.addr;
        m_mis_taken = bus.resolve_taken;
        q.delete();
      end else begin
        void'(q.pop_front());
        if (push) q.push_back(nw);
      end
    end else if (push) begin
      q.push_back(nw);
    end
  endtask

  always @(negedge clk) begin
    int n;
    bit rdy, rrdy, ps;
    if (chk_en) begin
      n    = q.size();
      rdy  = (n != DEPTH);
      rrdy = (n != 0) && (busy == 0);
      ps   = bus.fetch_valid && rdy;
      chk("fetch_ready", bus.fetch_ready, rdy);
      chk("resolve_ready", bus.resolve_ready, rrdy);
      chk("pred_start", bus.pred_start, ps);
      chk("fetch_pred", bus.fetch_pred, ps ? bus.pred_in : 1'b0);
      chk("pred_addr", bus.pred_addr, bus.fetch_addr);
      chk("pred_opcode", bus.pred_opcode, bus.fetch_opcode);
      chk("count", bus.count, n);
      chk("mispredict", bus.mispredict, m_mis);
      if (m_mis) begin
        chk("mispredict_addr", bus.mispredict_addr, m_mis_addr);
        chk("mispredict_taken", bus.mispredict_taken, m_mis_taken);
      end
      chk("upd_strobe", bus.upd_strobe, busy == 2);
      chk("upd_addr", bus.upd_addr, m_upd_addr);
      chk("upd_taken", bus.upd_taken, m_upd_taken);
    end
  end

  // Inputs change 1 time unit after the edge; the model advances on the edge.
  task automatic cyc(input bit fv, input logic [ADDR_W-1:0] fa, input logic [6:0] fo,
                     input bit pi, input bit rv, input bit rt);
    bus.fetch_valid   = fv;
    bus.fetch_addr    = fa;
    bus.fetch_opcode  = fo;
    bus.pred_in       = pi;
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, BR, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.fetch_valid   = 1'b0;
    bus.fetch_addr    = '0;
    bus.fetch_opcode  = '0;
    bus.pred_in       = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("rst_count", bus.count, 0);
    chk("rst_fetch_ready", bus.fetch_ready, 1);
    chk("rst_resolve_ready", bus.resolve_ready, 0);
    chk("rst_upd_strobe", bus.upd_strobe, 0);
    chk("rst_mispredict", bus.mispredict, 0);

    // Single branch, predicted not-taken, resolves taken.
    cyc(1, 8'h10, BR, 0, 0, 0);
    cyc(0, '0, BR, 0, 1, 1);
    chk("t1_mispredict", bus.mispredict, 1);
    chk("t1_mis_addr", bus.mispredict_addr, 8'h10);
    chk("t1_mis_taken", bus.mispredict_taken, 1);
    chk("t1_strobe_hi", bus.upd_strobe, 1);
    chk("t1_upd_addr", bus.upd_addr, 8'h10);
    chk("t1_upd_taken", bus.upd_taken, 1);
    chk("t1_count", bus.count, 0);
    idle(1);
    chk("t1_strobe_lo", bus.upd_strobe, 0);
    chk("t1_mis_clear", bus.mispredict, 0);
    idle(1);

    // Fill to DEPTH, attempt an overflow push, then drain with all-taken resolves.
    for (int i = 1; i <= DEPTH; i++) cyc(1, ADDR_W'(i), BR, 1, 0, 0);
    chk("t2_count_full", bus.count, DEPTH);
    chk("t2_fetch_ready", bus.fetch_ready, 0);
    cyc(1, 8'h09, BR, 1, 0, 0);
    chk("t2_no_overflow", bus.count, DEPTH);
    cyc(0, '0, BR, 0, 1, 1);
    chk("t2_first_upd", bus.upd_addr, 1);
    for (int i = 0; i < 10; i++) cyc(0, '0, BR, 0, 1, 1);
    chk("t2_last_upd", bus.upd_addr, DEPTH);
    chk("t2_drained", bus.count, 0);
    idle(2);

    // Flush with a same-cycle wrong-path push.
    cyc(1, 8'h20, BR, 1, 0, 0);
    cyc(1, 8'h21, BR, 1, 0, 0);
    cyc(1, 8'h22, BR, 1, 0, 0);
    cyc(1, 8'h33, BR, 1, 1, 0);
    chk("t3_mispredict", bus.mispredict, 1);
    chk("t3_mis_addr", bus.mispredict_addr, 8'h20);
    chk("t3_count", bus.count, 0);
    chk("t3_upd_taken", bus.upd_taken, 0);
    idle(2);

    // Jumps resolve back-to-back without an update.
    cyc(1, 8'h40, JAL, 1, 0, 0);
    cyc(1, 8'h41, JAL, 1, 0, 0);
    cyc(0, '0, BR, 0, 1, 1);
    chk("t4_no_strobe", bus.upd_strobe, 0);
    chk("t4_no_mis", bus.mispredict, 0);
    chk("t4_rready", bus.resolve_ready, 1);
    cyc(0, '0, BR, 0, 1, 1);
    chk("t4_empty", bus.count, 0);
    idle(1);

    // Asynchronous reset while the update pulse is high.
    cyc(1, 8'h50, BR, 1, 0, 0);
    cyc(1, 8'h52, BR, 1, 0, 0);
    cyc(0, '0, BR, 0, 1, 1);
    chk("t5_strobe_hi", bus.upd_strobe, 1);
    bus.resolve_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_strobe_fell", bus.upd_strobe, 0);
    chk("t5_count", bus.count, 0);
    chk("t5_rready", bus.resolve_ready, 0);
    chk("t5_upd_addr", bus.upd_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 8'h51, BR, 0, 0, 0);
    cyc(0, '0, BR, 0, 1, 0);
    chk("t5_post_strobe", bus.upd_strobe, 1);
    chk("t5_post_addr", bus.upd_addr, 8'h51);
    chk("t5_post_mis", bus.mispredict, 0);
    idle(2);

    // Concurrent push+pop at count 2 across pointer wrap.
    cyc(1, 8'h60, BR, 1, 0, 0);
    cyc(1, 8'h61, BR, 1, 0, 0);
    cyc(1, 8'h62, BR, 1, 1, 1);
    chk("t6_count_a", bus.count, 2);
    chk("t6_upd_a", bus.upd_addr, 8'h60);
    idle(2);
    cyc(1, 8'h63, BR, 1, 1, 1);
    chk("t6_count_b", bus.count, 2);
    chk("t6_upd_b", bus.upd_addr, 8'h61);
    idle(2);
    cyc(0, '0, BR, 0, 1, 1);
    chk("t6_upd_c", bus.upd_addr, 8'h62);
    idle(2);
    cyc(0, '0, BR, 0, 1, 1);
    chk("t6_upd_d", bus.upd_addr, 8'h63);
    idle(2);

    // Randomized traffic; resolves mostly agree with the head prediction.
    for (int i = 0; i < 3000; i++) begin
      bit                fv, pi, rv, rt;
      logic [ADDR_W-1:0] fa;
      logic [6:0]        fo;
      fv = ($urandom_range(0, 99) < 55);
      fa = ADDR_W'($urandom);
      fo = ($urandom_range(0, 9) < 7) ? BR : JAL;
      pi = $urandom_range(0, 1) == 1;
      rv = ($urandom_range(0, 99) < 60);
      rt = $urandom_range(0, 1) == 1;
      if (q.size() != 0) rt = ($urandom_range(0, 3) == 0) ? !q[0].pred : q[0].pred;
      cyc(fv, fa, fo, pi, rv, rt);
    end
    idle(3);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
